// File: rtl/dpram_be_init.sv
// Dual-port, single-clock word memory with per-byte write enables and registered reads.
// Port A serves the core load/store unit and port B serves the debug/DMA master.
// After every reset, an init sweep writes INIT_VAL into each word. The ports stay
// not-ready until that sweep has finished.
// If both ports touch the same word in the same cycle, the write happens first.
// A reader sees the merged post-write word. Where both ports write the same byte, B wins.
module dpram_be_init #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 256,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_err,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W/8-1:0]   b_be,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_err
);

    localparam int                BE_W     = DATA_W / 8;
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                a_acc, b_acc;
    logic                a_in, b_in;
    logic                a_wr, b_wr;
    logic [IDX_W-1:0]    a_idx, b_idx;
    logic [DATA_W-1:0]   a_fwd, b_fwd;

    // Expands the byte enables into a bit mask over the whole word.
    function automatic logic [DATA_W-1:0] byte_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // Overlays the enabled bytes of wdata onto an existing word.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] m;
        m = byte_mask(be);
        return (old_word & ~m) | (wdata & m);
    endfunction

    assign a_ready = init_done;
    assign b_ready = init_done;

    assign a_acc = a_req & init_done;
    assign b_acc = b_req & init_done;

    assign a_in  = ({1'b0, a_addr} < DEPTH_C);
    assign b_in  = ({1'b0, b_addr} < DEPTH_C);

    assign a_idx = a_addr[IDX_W-1:0];
    assign b_idx = b_addr[IDX_W-1:0];

    assign a_wr  = a_acc & a_we & a_in;
    assign b_wr  = b_acc & b_we & b_in;

    // Write-first forwarding: each reader sees the word as the other port leaves it this cycle.
    always_comb begin
        a_fwd = mem[a_idx];
        b_fwd = mem[b_idx];
        if (b_wr && (b_idx == a_idx)) begin
            a_fwd = merge_bytes(a_fwd, b_wdata, b_be);
        end
        if (a_wr && (a_idx == b_idx)) begin
            b_fwd = merge_bytes(b_fwd, a_wdata, a_be);
        end
    end

    // FSM (init sweep -> run) and the registered response outputs of both ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            a_rvalid  <= 1'b0;
            a_err     <= 1'b0;
            a_rdata   <= '0;
            b_rvalid  <= 1'b0;
            b_err     <= 1'b0;
            b_rdata   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
            endcase

            a_rvalid <= a_acc & ~a_we;
            a_err    <= a_acc & ~a_in;
            if (a_acc && !a_we) begin
                a_rdata <= a_in ? (a_fwd & byte_mask(a_be)) : '0;
            end

            b_rvalid <= b_acc & ~b_we;
            b_err    <= b_acc & ~b_in;
            if (b_acc && !b_we) begin
                b_rdata <= b_in ? (b_fwd & byte_mask(b_be)) : '0;
            end
        end
    end

    // Storage: the sweep writes INIT_VAL, then the byte writes run. B is applied last, so B wins shared bytes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                mem[cnt] <= INIT_VAL;
            end else begin
                for (int i = 0; i < BE_W; i++) begin
                    if (a_wr && a_be[i]) begin
                        mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                    end
                end
                for (int i = 0; i < BE_W; i++) begin
                    if (b_wr && b_be[i]) begin
                        mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dpram_be_init.sv
// Bench for dpram_be_init. Two instances share every input:
// d0 has DEPTH=256 and INIT_VAL=0, and d1 has DEPTH=200 and a non-zero INIT_VAL.
// Each read or error response is queued with its expected value and due cycle.
// A negedge monitor pops each queue and compares it against what each port presents.
module tb_dpram_be_init;

    localparam logic [31:0] INIT1 = 32'h5A5A_0FF0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_wdata, b_wdata;

    logic        d0_init_done, d0_a_ready, d0_a_rvalid, d0_a_err, d0_b_ready, d0_b_rvalid, d0_b_err;
    logic [31:0] d0_a_rdata, d0_b_rdata;
    logic        d1_init_done, d1_a_ready, d1_a_rvalid, d1_a_err, d1_b_ready, d1_b_rvalid, d1_b_err;
    logic [31:0] d1_a_rdata, d1_b_rdata;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        logic        rv;
        logic        er;
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t sb [4][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dpram_be_init #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .INIT_VAL(32'h0)) d0 (
        .clk(clk), .rst_n(rst_n), .init_done(d0_init_done),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_ready(d0_a_ready), .a_rvalid(d0_a_rvalid), .a_rdata(d0_a_rdata), .a_err(d0_a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_ready(d0_b_ready), .b_rvalid(d0_b_rvalid), .b_rdata(d0_b_rdata), .b_err(d0_b_err)
    );

    dpram_be_init #(.DATA_W(32), .DEPTH(200), .ADDR_W(8), .INIT_VAL(INIT1)) d1 (
        .clk(clk), .rst_n(rst_n), .init_done(d1_init_done),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_ready(d1_a_ready), .a_rvalid(d1_a_rvalid), .a_rdata(d1_a_rdata), .a_err(d1_a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_ready(d1_b_ready), .b_rvalid(d1_b_rvalid), .b_rdata(d1_b_rdata), .b_err(d1_b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_stream(input int s, input logic rv, input logic [31:0] d, input logic er);
        exp_t e;
        if (rv || er) begin
            n_total++;
            if (sb[s].size() == 0) begin
                $display("FAIL stream%0d unexpected: rv=%b err=%b data=%h cyc=%0d", s, rv, er, d, cyc);
            end else begin
                e = sb[s].pop_front();
                if (rv !== e.rv || er !== e.er || (e.rv && d !== e.d) || cyc != e.due)
                    $display("FAIL stream%0d: rv=%b err=%b data=%h cyc=%0d, expected rv=%b err=%b data=%h cyc=%0d",
                             s, rv, er, d, cyc, e.rv, e.er, e.d, e.due);
                else
                    n_pass++;
            end
        end
    endtask

    // Streams: 0 = d0 port A, 1 = d0 port B, 2 = d1 port A, 3 = d1 port B
    always @(negedge clk) begin
        check_stream(0, d0_a_rvalid, d0_a_rdata, d0_a_err);
        check_stream(1, d0_b_rvalid, d0_b_rdata, d0_b_err);
        check_stream(2, d1_a_rvalid, d1_a_rdata, d1_a_err);
        check_stream(3, d1_b_rvalid, d1_b_rdata, d1_b_err);
    end

    task automatic push(input int s, input logic rv, input logic [31:0] d, input logic er);
        exp_t e;
        e.rv = rv; e.er = er; e.d = d; e.due = cyc + 1;
        sb[s].push_back(e);
    endtask

    task automatic set_a(input logic we, input logic [7:0] addr, input logic [3:0] be, input logic [31:0] wd);
        a_req = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
    endtask

    task automatic set_b(input logic we, input logic [7:0] addr, input logic [3:0] be, input logic [31:0] wd);
        b_req = 1'b1; b_we = we; b_addr = addr; b_be = be; b_wdata = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    // Counts edges after reset release until each instance raises init_done.
    // Any request present is withdrawn after `hold` cycles.
    task automatic wait_init(input int hold);
        int c0, c1;
        c0 = -1; c1 = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk("ready_during_init", {31'b0, d0_a_ready}, 32'd0);
            if (k == hold) begin a_req = 1'b0; b_req = 1'b0; end
            if (c0 < 0 && d0_init_done) c0 = k;
            if (c1 < 0 && d1_init_done) c1 = k;
            if (c0 >= 0 && c1 >= 0) break;
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("init_cycles_d0", 32'(c0), 32'd256);
        chk("init_cycles_d1", 32'(c1), 32'd200);
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_be = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init_done", {31'b0, d0_init_done}, 32'd0);
        chk("rst_a_ready",   {31'b0, d0_a_ready},   32'd0);
        chk("rst_b_ready",   {31'b0, d1_b_ready},   32'd0);
        chk("rst_a_rvalid",  {31'b0, d0_a_rvalid},  32'd0);
        chk("rst_a_rdata",   d0_a_rdata,            32'd0);
        chk("rst_b_rdata",   d1_b_rdata,            32'd0);
        chk("rst_a_err",     {31'b0, d1_a_err},     32'd0);
        rst_n = 1'b1;
        wait_init(0);

        // Full-throughput sweep read on both ports
        for (int i = 0; i < 256; i++) begin
            set_a(1'b0, 8'(i), 4'b1111, 32'h0);
            set_b(1'b0, 8'(255 - i), 4'b0101, 32'h0);
            push(0, 1'b1, 32'h0, 1'b0);
            push(1, 1'b1, 32'h0, 1'b0);
            if (i < 200) push(2, 1'b1, INIT1, 1'b0);
            else         push(2, 1'b1, 32'h0, 1'b1);
            if (255 - i < 200) push(3, 1'b1, 32'h005A_00F0, 1'b0);
            else               push(3, 1'b1, 32'h0, 1'b1);
            step();
        end

        // Byte-merge writes, a masked read, a be=0 no-op, and rdata hold
        set_a(1'b1, 8'd5, 4'b1111, 32'hDEAD_BEEF); step();
        set_a(1'b1, 8'd5, 4'b0010, 32'h0000_1100); step();
        set_a(1'b0, 8'd5, 4'b1111, 32'h0);
        push(0, 1'b1, 32'hDEAD_11EF, 1'b0); push(2, 1'b1, 32'hDEAD_11EF, 1'b0); step();
        step();
        chk("rdata_hold", d0_a_rdata, 32'hDEAD_11EF);
        chk("rvalid_idle", {31'b0, d0_a_rvalid}, 32'd0);
        set_a(1'b1, 8'd5, 4'b0000, 32'hFFFF_FFFF); step();
        set_a(1'b0, 8'd5, 4'b1001, 32'h0);
        push(0, 1'b1, 32'hDE00_00EF, 1'b0); push(2, 1'b1, 32'hDE00_00EF, 1'b0); step();

        // Same-cycle write/write on address 9
        set_a(1'b1, 8'd9, 4'b0011, 32'h1111_1111);
        set_b(1'b1, 8'd9, 4'b0110, 32'h2222_2222); step();
        set_b(1'b0, 8'd9, 4'b1111, 32'h0);
        push(1, 1'b1, 32'h0022_2211, 1'b0); push(3, 1'b1, 32'h5A22_2211, 1'b0); step();

        // Read/write and read/read collisions on address 3
        set_a(1'b0, 8'd3, 4'b1111, 32'h0);
        set_b(1'b1, 8'd3, 4'b1111, 32'hCAFE_F00D);
        push(0, 1'b1, 32'hCAFE_F00D, 1'b0); push(2, 1'b1, 32'hCAFE_F00D, 1'b0); step();
        set_a(1'b0, 8'd3, 4'b1111, 32'h0);
        set_b(1'b0, 8'd3, 4'b1111, 32'h0);
        push(0, 1'b1, 32'hCAFE_F00D, 1'b0); push(1, 1'b1, 32'hCAFE_F00D, 1'b0);
        push(2, 1'b1, 32'hCAFE_F00D, 1'b0); push(3, 1'b1, 32'hCAFE_F00D, 1'b0); step();
        set_a(1'b1, 8'd3, 4'b0001, 32'h0000_00AA);
        set_b(1'b0, 8'd3, 4'b1111, 32'h0);
        push(1, 1'b1, 32'hCAFE_F0AA, 1'b0); push(3, 1'b1, 32'hCAFE_F0AA, 1'b0); step();
        set_a(1'b1, 8'd3, 4'b1100, 32'h8899_0000);
        set_b(1'b1, 8'd3, 4'b1000, 32'h7700_0000); step();
        set_a(1'b0, 8'd3, 4'b1111, 32'h0);
        push(0, 1'b1, 32'h7799_F0AA, 1'b0); push(2, 1'b1, 32'h7799_F0AA, 1'b0); step();

        // Out-of-range accesses on d1 (DEPTH=200); the same addresses are in range on d0
        set_a(1'b0, 8'd210, 4'b1111, 32'h0);
        push(0, 1'b1, 32'h0, 1'b0); push(2, 1'b1, 32'h0, 1'b1); step();
        set_a(1'b1, 8'd250, 4'b1111, 32'h1234_5678);
        push(2, 1'b0, 32'h0, 1'b1); step();
        set_a(1'b0, 8'd250, 4'b1111, 32'h0);
        push(0, 1'b1, 32'h1234_5678, 1'b0); push(2, 1'b1, 32'h0, 1'b1); step();
        set_b(1'b0, 8'd50, 4'b1111, 32'h0);
        push(1, 1'b1, 32'h0, 1'b0); push(3, 1'b1, INIT1, 1'b0); step();

        // Reset at sweep count 100, then a read issued during init that must be ignored
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (100) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        set_a(1'b0, 8'd9, 4'b1111, 32'h0);
        wait_init(5);
        set_a(1'b0, 8'd9, 4'b1111, 32'h0);
        push(0, 1'b1, 32'h0, 1'b0); push(2, 1'b1, INIT1, 1'b0); step();

        // Reset drops a read presented in the same cycle
        set_a(1'b0, 8'd5, 4'b1111, 32'h0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("dropped_rvalid", {31'b0, d0_a_rvalid}, 32'd0);
        chk("init_done_low",  {31'b0, d0_init_done}, 32'd0);
        wait_init(0);
        set_a(1'b0, 8'd5, 4'b1111, 32'h0);
        push(0, 1'b1, 32'h0, 1'b0); push(2, 1'b1, INIT1, 1'b0); step();

        repeat (3) step();
        for (int s = 0; s < 4; s++) chk($sformatf("sb_empty%0d", s), 32'(sb[s].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
